// File: rtl/bit_stats_seq_pkg.sv
// Shared constants for the bit-statistics scanner: FSM encodings and result-width helper.
package bit_stats_seq_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Bits needed to hold a count in 0..w inclusive.
  function automatic int unsigned cw_of(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_stats_lane.sv
// One LANE-bit slice of the scan: folds the lane LSB->MSB into the running zero-run/seen state.
module bit_stats_lane #(
  parameter int unsigned LANE = 4,
  parameter int unsigned CW   = 5
) (
  input  logic [LANE-1:0] bits,
  input  logic [CW-1:0]   zrun_in,
  input  logic            seen_in,
  output logic [CW-1:0]   ones,
  output logic [CW-1:0]   zsig,
  output logic [CW-1:0]   zrun_out,
  output logic [CW-1:0]   tz_add,
  output logic            seen_out
);

  logic [CW-1:0] zr;
  logic          sn;

  // A one commits the pending zero run as significant; zeros before any one are trailing.
  always_comb begin
    ones   = '0;
    zsig   = '0;
    tz_add = '0;
    zr     = zrun_in;
    sn     = seen_in;
    for (int i = 0; i < int'(LANE); i++) begin
      if (bits[i]) begin
        ones = ones + CW'(1);
        zsig = zsig + zr;
        zr   = '0;
        sn   = 1'b1;
      end else begin
        zr = zr + CW'(1);
        if (!sn) tz_add = tz_add + CW'(1);
      end
    end
    zrun_out = zr;
    seen_out = sn;
  end

endmodule

// File: rtl/bit_stats_seq.sv
// Multi-cycle bit-statistics unit: scans a captured operand LANE bits per clock and
// reports ones, significant zeros, bit length, trailing zeros and a zero flag.
module bit_stats_seq
  import bit_stats_seq_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned LANE  = 4,
  localparam int unsigned CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    o,
  output logic [CW-1:0]    z,
  output logic [CW-1:0]    b,
  output logic [CW-1:0]    tz,
  output logic             zero
);

  localparam int unsigned NSTEP = WIDTH / LANE;
  localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic [CW-1:0]    acc_o, acc_o_nxt;
  logic [CW-1:0]    acc_z, acc_z_nxt;
  logic [CW-1:0]    zrun, zrun_nxt;
  logic [CW-1:0]    acc_tz, acc_tz_nxt;
  logic             seen, seen_nxt;
  logic             busy_nxt, done_nxt, zero_nxt;
  logic [CW-1:0]    o_nxt, z_nxt, b_nxt, tz_nxt;

  logic [CW-1:0]    l_ones, l_zsig, l_zrun, l_tz;
  logic             l_seen;

  bit_stats_lane #(
    .LANE (LANE),
    .CW   (CW)
  ) u_lane (
    .bits     (shreg[LANE-1:0]),
    .zrun_in  (zrun),
    .seen_in  (seen),
    .ones     (l_ones),
    .zsig     (l_zsig),
    .zrun_out (l_zrun),
    .tz_add   (l_tz),
    .seen_out (l_seen)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    step_nxt   = step;
    acc_o_nxt  = acc_o;
    acc_z_nxt  = acc_z;
    zrun_nxt   = zrun;
    acc_tz_nxt = acc_tz;
    seen_nxt   = seen;
    done_nxt   = 1'b0;
    o_nxt      = o;
    z_nxt      = z;
    b_nxt      = b;
    tz_nxt     = tz;
    zero_nxt   = zero;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_SCAN;
          shreg_nxt  = num;
          step_nxt   = '0;
          acc_o_nxt  = '0;
          acc_z_nxt  = '0;
          zrun_nxt   = '0;
          acc_tz_nxt = '0;
          seen_nxt   = 1'b0;
        end
      end
      ST_SCAN: begin
        shreg_nxt  = shreg >> LANE;
        step_nxt   = step + SW'(1);
        acc_o_nxt  = acc_o + l_ones;
        acc_z_nxt  = acc_z + l_zsig;
        zrun_nxt   = l_zrun;
        acc_tz_nxt = acc_tz + l_tz;
        seen_nxt   = l_seen;
        // Final lane: publish results; any leftover zero run is leading zeros and dropped.
        if (step == SW'(NSTEP - 1)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
          o_nxt     = acc_o_nxt;
          z_nxt     = acc_z_nxt;
          b_nxt     = acc_o_nxt + acc_z_nxt;
          tz_nxt    = acc_tz_nxt;
          zero_nxt  = ~seen_nxt;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_SCAN);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      step   <= '0;
      acc_o  <= '0;
      acc_z  <= '0;
      zrun   <= '0;
      acc_tz <= '0;
      seen   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      o      <= '0;
      z      <= '0;
      b      <= '0;
      tz     <= '0;
      zero   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      step   <= step_nxt;
      acc_o  <= acc_o_nxt;
      acc_z  <= acc_z_nxt;
      zrun   <= zrun_nxt;
      acc_tz <= acc_tz_nxt;
      seen   <= seen_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      o      <= o_nxt;
      z      <= z_nxt;
      b      <= b_nxt;
      tz     <= tz_nxt;
      zero   <= zero_nxt;
    end
  end

endmodule
